// File: rtl/carpma_birimi.sv
`default_nettype none
// ============================================================================
//  Module      : carpma_birimi
//  Description : RV32M multiply unit (MUL/MULH/MULHSU/MULHU), registered result.
//  Revision    : 1.0 - initial release
// ============================================================================
module carpma_birimi (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        durdur_i,
    input  logic [1:0]  kontrol_i,
    input  logic [31:0] deger1_i,
    input  logic [31:0] deger2_i,
    output logic [31:0] sonuc_o
);

    localparam logic [1:0] CARPMA_MUL    = 2'b00;
    localparam logic [1:0] CARPMA_MULH   = 2'b01;
    localparam logic [1:0] CARPMA_MULHSU = 2'b10;
    localparam logic [1:0] CARPMA_MULHU  = 2'b11;

    logic        w_isaret1;
    logic        w_isaret2;
    logic [63:0] w_genis1;
    logic [63:0] w_genis2;
    logic [63:0] w_carpim;
    logic [31:0] w_secim;
    logic [31:0] r_sonuc;

    assign w_isaret1 = (kontrol_i != CARPMA_MULHU) & deger1_i[31];
    assign w_isaret2 = ((kontrol_i == CARPMA_MUL) | (kontrol_i == CARPMA_MULH)) & deger2_i[31];

    // Extending straight to 64 bits yields the same low 64 bits as the 33x33 signed product.
    assign w_genis1 = {{32{w_isaret1}}, deger1_i};
    assign w_genis2 = {{32{w_isaret2}}, deger2_i};
    assign w_carpim = w_genis1 * w_genis2;

    assign w_secim  = (kontrol_i == CARPMA_MUL) ? w_carpim[31:0] : w_carpim[63:32];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sonuc <= 32'h0000_0000;
        end else if (!durdur_i) begin
            r_sonuc <= w_secim;
        end
    end

    assign sonuc_o = r_sonuc;

endmodule
`default_nettype wire

// File: tb/tb_carpma_birimi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_carpma_birimi
//  Description : Directed self-checking bench for carpma_birimi.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_carpma_birimi;

    localparam logic [1:0] C_MUL    = 2'b00;
    localparam logic [1:0] C_MULH   = 2'b01;
    localparam logic [1:0] C_MULHSU = 2'b10;
    localparam logic [1:0] C_MULHU  = 2'b11;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        durdur_i;
    logic [1:0]  kontrol_i;
    logic [31:0] deger1_i;
    logic [31:0] deger2_i;
    logic [31:0] sonuc_o;

    int n_pass  = 0;
    int n_check = 0;

    carpma_birimi dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .durdur_i  (durdur_i),
        .kontrol_i (kontrol_i),
        .deger1_i  (deger1_i),
        .deger2_i  (deger2_i),
        .sonuc_o   (sonuc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic kontrol_et(input string tag, input logic [31:0] beklenen);
        n_check++;
        assert (sonuc_o === beklenen) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, sonuc_o, beklenen);
    endtask

    // Drive operands, clock once, sample 1 ns after the edge.
    task automatic adim(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        kontrol_i = op;
        deger1_i  = a;
        deger2_i  = b;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i     = 1'b1;
        durdur_i  = 1'b0;
        kontrol_i = C_MUL;
        deger1_i  = 32'd5;
        deger2_i  = 32'd7;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        kontrol_et("reset", 32'h0000_0000);
        rst_i = 1'b0;

        // MUL
        adim(C_MUL, 32'd121, 32'd70);               kontrol_et("mul_pp", 32'd8470);
        adim(C_MUL, 32'd121, 32'hFFFF_FFBA);        kontrol_et("mul_pn", 32'hFFFF_DEEA);
        adim(C_MUL, 32'hFFFF_FF87, 32'd70);         kontrol_et("mul_np", 32'hFFFF_DEEA);
        adim(C_MUL, 32'h0F00_0000, 32'h0F00_0000);  kontrol_et("mul_sq", 32'h0000_0000);
        adim(C_MUL, 32'd121, 32'hFFFF_FFFF);        kontrol_et("mul_m1", 32'hFFFF_FF87);
        adim(C_MUL, 32'hFFFF_FF87, 32'd0);          kontrol_et("mul_z", 32'h0000_0000);

        // MULH
        adim(C_MULH, 32'h0011_0000, 32'h0003_0000); kontrol_et("mulh_pp", 32'd51);
        adim(C_MULH, 32'h0011_0000, 32'hFFFF_FFFF); kontrol_et("mulh_pn", 32'hFFFF_FFFF);
        adim(C_MULH, 32'hFFFF_FFFF, 32'h0011_0000); kontrol_et("mulh_np", 32'hFFFF_FFFF);
        adim(C_MULH, 32'hFFFF_FFFF, 32'd0);         kontrol_et("mulh_z", 32'h0000_0000);
        adim(C_MULH, 32'h8000_0000, 32'h8000_0000); kontrol_et("mulh_min", 32'h4000_0000);

        // MULHU
        adim(C_MULHU, 32'h0011_0000, 32'h0003_0000); kontrol_et("mulhu_pp", 32'd51);
        adim(C_MULHU, 32'h0011_0000, 32'hFFFF_FFFF); kontrol_et("mulhu_ab", 32'h0010_FFFF);
        adim(C_MULHU, 32'hFFFF_FFFF, 32'h0011_0000); kontrol_et("mulhu_ba", 32'h0010_FFFF);
        adim(C_MULHU, 32'hFFFF_FFFF, 32'd0);         kontrol_et("mulhu_z", 32'h0000_0000);
        adim(C_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); kontrol_et("mulhu_max", 32'hFFFF_FFFE);

        // MULHSU
        adim(C_MULHSU, 32'h0011_0000, 32'hFFFF_FFFF); kontrol_et("mulhsu_ab", 32'h0010_FFFF);
        adim(C_MULHSU, 32'hFFFF_FFFF, 32'h0011_0000); kontrol_et("mulhsu_ba", 32'hFFFF_FFFF);
        adim(C_MULHSU, 32'h0011_0000, 32'h0003_0000); kontrol_et("mulhsu_pp", 32'd51);

        // Stall: result frozen while operands change
        adim(C_MUL, 32'd121, 32'd70);               kontrol_et("pre_stall", 32'd8470);
        durdur_i = 1'b1;
        adim(C_MUL, 32'd3, 32'd4);                  kontrol_et("stall1", 32'd8470);
        adim(C_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); kontrol_et("stall2", 32'd8470);
        adim(C_MUL, 32'd9, 32'd9);                  kontrol_et("stall3", 32'd8470);
        durdur_i = 1'b0;
        adim(C_MUL, 32'd9, 32'd9);                  kontrol_et("stall_rel", 32'd81);

        // Reset mid-stream, with stall asserted as well
        adim(C_MUL, 32'd6, 32'd7);                  kontrol_et("pre_rst", 32'd42);
        rst_i    = 1'b1;
        durdur_i = 1'b1;
        adim(C_MUL, 32'd100, 32'd100);              kontrol_et("rst_stall", 32'h0000_0000);
        durdur_i = 1'b0;
        adim(C_MUL, 32'd100, 32'd100);              kontrol_et("rst_only", 32'h0000_0000);
        rst_i = 1'b0;
        adim(C_MUL, 32'd100, 32'd100);              kontrol_et("post_rst", 32'd10000);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
`default_nettype wire
